// File: rtl/chameleon_pkg.sv
// Shared types and constants for the bias-memory control path.
package chameleon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } bias_reader_state_t;

  localparam int BIAS_FIFO_DEPTH = 2;

endpackage

// File: rtl/bias_skid_fifo.sv
// Two-entry fall-through FIFO: when empty, incoming data is presented on the output in the
// same cycle and is only stored if the consumer does not take it.
module bias_skid_fifo
  import chameleon_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] r_mem [BIAS_FIFO_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_empty   = (r_count == 2'd0);
  assign w_pop     = out_ready && !w_empty;
  assign w_push    = in_valid && !(w_empty && out_ready);
  assign out_valid = !w_empty || in_valid;
  assign out_data  = !w_empty ? r_mem[r_rd_ptr] : (in_valid ? in_data : '0);
  assign count     = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= in_data;
  end

endmodule

// File: rtl/bias_stream_reader.sv
// Sequential reader of the bias memory streaming words out over valid/ready.
// Optional stall_cycles port enabled by defining CHAMELEON_BIAS_STALL_COUNTER_EN.
module bias_stream_reader
  import chameleon_pkg::*;
#(
  parameter int  BIAS_WORD_BIT_WIDTH = 64,
  parameter int  BIAS_ROWS           = 32,
  localparam int BIAS_ADDRESS_WIDTH  = $clog2(BIAS_ROWS),
  localparam int COUNT_WIDTH         = BIAS_ADDRESS_WIDTH + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [BIAS_ADDRESS_WIDTH-1:0]  base_address,
  input  logic [COUNT_WIDTH-1:0]         num_words,
  input  logic                           global_power_down,
  output logic                           bias_control_chip_select,
  output logic                           bias_control_write_enable,
  output logic [BIAS_ADDRESS_WIDTH-1:0]  bias_control_address,
  output logic [BIAS_WORD_BIT_WIDTH-1:0] bias_control_data_in,
  output logic [BIAS_WORD_BIT_WIDTH-1:0] bias_control_mask,
  input  logic [BIAS_WORD_BIT_WIDTH-1:0] bias_data_out,
  output logic [BIAS_WORD_BIT_WIDTH-1:0] bias_word,
  output logic                           bias_valid,
  input  logic                           bias_ready,
  output logic                           busy,
  output logic                           done
`ifdef CHAMELEON_BIAS_STALL_COUNTER_EN
  ,
  output logic [15:0]                    stall_cycles
`endif
);

  bias_reader_state_t            r_state;
  bias_reader_state_t            w_state_next;
  logic [BIAS_ADDRESS_WIDTH-1:0] r_base;
  logic [COUNT_WIDTH-1:0]        r_num;
  logic [COUNT_WIDTH-1:0]        r_issued;
  logic [COUNT_WIDTH-1:0]        r_accepted;
  logic                          r_inflight;
  logic                          r_done;
  logic                          w_done_next;
  logic [1:0]                    w_fifo_count;
  logic                          w_credit_ok;
  logic                          w_cs;
  logic                          w_accept;
  logic                          w_start_ok;
  logic                          w_last_issue;
  logic                          w_last_accept;

  // Stored words plus the read still in flight may never exceed the FIFO depth.
  assign w_credit_ok   = ({1'b0, w_fifo_count} + {2'b00, r_inflight}) < 3'(BIAS_FIFO_DEPTH);
  assign w_cs          = (r_state == FETCH) && !global_power_down && !abort && w_credit_ok;
  assign w_accept      = bias_valid && bias_ready;
  assign w_start_ok    = start && (r_state == IDLE) && !abort;
  assign w_last_issue  = w_cs && (r_issued == r_num - COUNT_WIDTH'(1));
  assign w_last_accept = w_accept && (r_accepted == r_num - COUNT_WIDTH'(1));

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    if (abort) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (num_words != '0) w_state_next = FETCH;
            else                 w_done_next  = 1'b1;
          end
        end
        FETCH: if (w_last_issue) w_state_next = DRAIN;
        DRAIN: begin
          if (w_last_accept) begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_done     <= 1'b0;
      r_inflight <= 1'b0;
      r_base     <= '0;
      r_num      <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
    end else begin
      r_state    <= w_state_next;
      r_done     <= w_done_next;
      r_inflight <= w_cs;
      if (w_start_ok) begin
        r_base     <= base_address;
        r_num      <= num_words;
        r_issued   <= '0;
        r_accepted <= '0;
      end else begin
        if (w_cs)     r_issued   <= r_issued + COUNT_WIDTH'(1);
        if (w_accept) r_accepted <= r_accepted + COUNT_WIDTH'(1);
      end
    end
  end

  // Abort flushes the FIFO; the aborted cycle issues nothing, so no return follows.
  bias_skid_fifo #(
    .WIDTH(BIAS_WORD_BIT_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (abort),
    .in_valid (r_inflight),
    .in_data  (bias_data_out),
    .out_ready(bias_ready),
    .out_valid(bias_valid),
    .out_data (bias_word),
    .count    (w_fifo_count)
  );

  assign bias_control_chip_select  = w_cs;
  assign bias_control_write_enable = 1'b0;
  assign bias_control_address      = w_cs ? (r_base + r_issued[BIAS_ADDRESS_WIDTH-1:0]) : '0;
  assign bias_control_data_in      = '0;
  assign bias_control_mask         = '0;
  assign busy                      = (r_state != IDLE);
  assign done                      = r_done;

`ifdef CHAMELEON_BIAS_STALL_COUNTER_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= 16'd0;
    end else if (w_start_ok) begin
      r_stall <= 16'd0;
    end else if (bias_valid && !bias_ready && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_bias_stream_reader.sv
// Directed and randomized bench for bias_stream_reader against a row-array memory model
// and an in-order expected-word scoreboard.
module tb_bias_stream_reader;

  localparam int BW   = 64;
  localparam int ROWS = 32;
  localparam int AW   = 5;
  localparam int CW   = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          global_power_down = 1'b0;
  logic          bias_ready = 1'b0;
  logic [AW-1:0] base_address = '0;
  logic [CW-1:0] num_words = '0;
  logic          cs, we;
  logic [AW-1:0] addr;
  logic [BW-1:0] din, mask, bias_word;
  logic [BW-1:0] rdata = '0;
  logic          bias_valid, busy, done;
`ifdef CHAMELEON_BIAS_STALL_COUNTER_EN
  logic [15:0]   stall_cycles;
`endif

  int errors = 0, checks = 0, cyc = 0, t0 = 0;
  logic [BW-1:0] mem [ROWS];
  logic [BW-1:0] exp_q [$];
  int cs_rel [$], cs_addr [$], acc_rel [$], done_rel [$];
  int issued_tot, accepted_tot, max_out, busy_cycles, unstable;
  logic [BW-1:0] held_word;
  bit holding = 0;
  logic last_valid, last_busy;

  bias_stream_reader dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .start                    (start),
    .abort                    (abort),
    .base_address             (base_address),
    .num_words                (num_words),
    .global_power_down        (global_power_down),
    .bias_control_chip_select (cs),
    .bias_control_write_enable(we),
    .bias_control_address     (addr),
    .bias_control_data_in     (din),
    .bias_control_mask        (mask),
    .bias_data_out            (rdata),
    .bias_word                (bias_word),
    .bias_valid               (bias_valid),
    .bias_ready               (bias_ready),
    .busy                     (busy),
    .done                     (done)
`ifdef CHAMELEON_BIAS_STALL_COUNTER_EN
    ,
    .stall_cycles             (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Memory with one cycle of read latency.
  always @(posedge clk) if (cs) rdata <= mem[addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    last_valid = bias_valid;
    last_busy  = busy;
    if (cs) begin
      cs_rel.push_back(cyc - t0);
      cs_addr.push_back(int'(addr));
      issued_tot++;
    end
    if (busy) busy_cycles++;
    if (done) done_rel.push_back(cyc - t0);
    if (bias_valid && !bias_ready) begin
      if (holding && bias_word !== held_word) unstable++;
      held_word = bias_word;
      holding = 1;
    end else begin
      holding = 0;
    end
    if (bias_valid && bias_ready) begin
      accepted_tot++;
      acc_rel.push_back(cyc - t0);
      if (exp_q.size() == 0) check("word_unexpected", 64'(exp_q.size()), 64'd1);
      else                   check("word", bias_word, exp_q.pop_front());
    end
    if (issued_tot - accepted_tot > max_out) max_out = issued_tot - accepted_tot;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic begin_xfer(input int b, input int n);
    cs_rel.delete(); cs_addr.delete(); acc_rel.delete(); done_rel.delete(); exp_q.delete();
    issued_tot = 0; accepted_tot = 0; max_out = 0; busy_cycles = 0; unstable = 0;
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(b + i) % ROWS]);
    base_address = AW'(b);
    num_words    = CW'(n);
    start = 1'b1;
    t0 = cyc;
    run_cycle();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int limit, input bit rnd_ready);
    for (int i = 0; i < limit && done_rel.size() == 0; i++) begin
      if (rnd_ready) bias_ready = ($urandom_range(3) != 0);
      run_cycle();
    end
    check("done_seen", 64'(done_rel.size()), 64'd1);
    check("all_words_delivered", 64'(exp_q.size()), 64'd0);
    $display("xfer base=%0d num=%0d reads=%0d accepted=%0d cycles=%0d",
             base_address, num_words, issued_tot, accepted_tot, cyc - t0);
  endtask

  initial begin
    int b, n, bad;
    for (int i = 0; i < ROWS; i++) mem[i] = {$urandom, $urandom};

    // Reset state
    @(negedge clk);
    check("rst_ctrl", 64'({cs, we, bias_valid, busy, done}), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_word", bias_word, 64'd0);
    check("rst_din_mask", din | mask, 64'd0);
`ifdef CHAMELEON_BIAS_STALL_COUNTER_EN
    check("rst_stall", 64'(stall_cycles), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_cycle();
    run_cycle();

    // base=0 num=4 with ready high: exact cycle timing
    bias_ready = 1'b1;
    begin_xfer(0, 4);
    run_to_done(20, 0);
    check("t1_cs_count", 64'(cs_rel.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("t1_cs_addr",  64'(i < cs_addr.size() ? cs_addr[i] : -1), 64'(i));
      check("t1_cs_cycle", 64'(i < cs_rel.size()  ? cs_rel[i]  : -1), 64'(i + 1));
      check("t1_acc_cycle", 64'(i < acc_rel.size() ? acc_rel[i] : -1), 64'(i + 2));
    end
    check("t1_done_cycle", 64'(done_rel.size() > 0 ? done_rel[0] : -1), 64'd6);

    // Address wrap at top row
    begin_xfer(30, 4);
    run_to_done(20, 0);
    for (int i = 0; i < 4; i++)
      check("t2_wrap_addr", 64'(i < cs_addr.size() ? cs_addr[i] : -1), 64'((30 + i) % ROWS));

    // Backpressure: ready low for 5 cycles while a word is waiting
    b = $urandom_range(ROWS - 1);
    begin_xfer(b, 6);
    run_cycle();
    bias_ready = 1'b0;
    repeat (5) run_cycle();
    bias_ready = 1'b1;
    run_to_done(30, 0);
    check("t3_max_outstanding", 64'(max_out), 64'd2);
    check("t3_word_stable", 64'(unstable), 64'd0);
    check("t3_accepted", 64'(accepted_tot), 64'd6);
`ifdef CHAMELEON_BIAS_STALL_COUNTER_EN
    check("t3_stall_cycles", 64'(stall_cycles), 64'd5);
`endif

    // Zero-length transfer
    begin_xfer(7, 0);
    repeat (3) run_cycle();
    check("t4_done_count", 64'(done_rel.size()), 64'd1);
    check("t4_done_cycle", 64'(done_rel.size() > 0 ? done_rel[0] : -1), 64'd1);
    check("t4_no_reads", 64'(cs_rel.size()), 64'd0);
    check("t4_never_busy", 64'(busy_cycles), 64'd0);

    // Abort in the cycle after the second read issues
    begin_xfer(5, 8);
    run_cycle();
    run_cycle();
    abort = 1'b1;
    run_cycle();
    abort = 1'b0;
    run_cycle();
    check("t5_valid_after_abort", 64'(last_valid), 64'd0);
    check("t5_busy_after_abort", 64'(last_busy), 64'd0);
    repeat (4) run_cycle();
    check("t5_reads_before_abort", 64'(cs_rel.size()), 64'd2);
    check("t5_no_done", 64'(done_rel.size()), 64'd0);
    begin_xfer(20, 3);
    run_to_done(20, 0);
    check("t5_restart_addr", 64'(cs_addr.size() > 0 ? cs_addr[0] : -1), 64'd20);

    // Power-down pause mid-FETCH
    begin_xfer(10, 8);
    run_cycle();
    run_cycle();
    global_power_down = 1'b1;
    repeat (3) run_cycle();
    global_power_down = 1'b0;
    run_to_done(40, 0);
    bad = 0;
    foreach (cs_rel[i]) if (cs_rel[i] >= 3 && cs_rel[i] <= 5) bad++;
    check("t6_no_cs_in_pd", 64'(bad), 64'd0);
    check("t6_resume_cycle", 64'(cs_rel.size() > 2 ? cs_rel[2] : -1), 64'd6);
    bad = 0;
    foreach (cs_addr[i]) if (cs_addr[i] != (10 + i) % ROWS) bad++;
    check("t6_addr_seq", 64'(bad), 64'd0);
    check("t6_cs_count", 64'(cs_rel.size()), 64'd8);

    // Randomized transfers with random backpressure
    repeat (5) begin
      b = $urandom_range(ROWS - 1);
      n = $urandom_range(ROWS, 1);
      bias_ready = 1'b1;
      begin_xfer(b, n);
      run_to_done(400, 1);
      check("t7_accepted", 64'(accepted_tot), 64'(n));
      check("t7_outstanding_le2", 64'(max_out <= 2), 64'd1);
    end
    bias_ready = 1'b1;

    // Asynchronous reset in the middle of FETCH
    bias_ready = 1'b0;
    begin_xfer(0, 16);
    run_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("t8_rst_ctrl", 64'({cs, bias_valid, busy, done}), 64'd0);
    check("t8_rst_addr", 64'(addr), 64'd0);
    check("t8_rst_word", bias_word, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bias_ready = 1'b1;
    run_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
